bcd_7seg_scan_driver: RTL and testbench

- Downstream consumer of the binary-to-BCD converter's packed BCD vector and its one-cycle done strobe.
- Holds the value and time-multiplexes it onto a common-anode multi-digit 7-segment display.
- Inserts a blanking interval between digits to suppress ghosting.
- Updates the shown value only at frame boundaries, so no digit ever displays a half-updated number.

---
 rtl/seg7_pkg.sv | 28 ++
 rtl/bcd_7seg_scan_driver_if.sv | 18 +
 rtl/bcd_to_seg7.sv | 32 +++
 rtl/bcd_7seg_scan_driver.sv | 213 +++++++++++++++++++++
 tb/tb_bcd_7seg_scan_driver.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared constants for the 7-segment scan driver: active-high glyph patterns
// in {g,f,e,d,c,b,a} order, the all-off pattern, and the scan FSM states.
// ---------------------------------------------------------------------------
package seg7_pkg;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;

  // Active-low pattern with every segment dark.
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  typedef enum logic {
    s_BLANK = 1'b0,
    s_DRIVE = 1'b1
  } scan_state_t;

endpackage

// File: rtl/bcd_7seg_scan_driver_if.sv
// ---------------------------------------------------------------------------
// bcd_7seg_scan_driver_if
// Input bundle from the binary-to-BCD converter to the scan driver.
//   i_BCD : packed BCD, digit k in bits [4k+3:4k]
//   i_DV  : one-cycle strobe, i_BCD/i_DP valid this cycle
//   i_DP  : decimal-point enables, bit k belongs to digit k
// master = converter side (drives), slave = scan driver side (receives).
// ---------------------------------------------------------------------------
interface bcd_7seg_scan_driver_if #(
  parameter int DECIMAL_DIGITS = 4
);
  logic [DECIMAL_DIGITS*4-1:0] i_BCD;
  logic                        i_DV;
  logic [DECIMAL_DIGITS-1:0]   i_DP;

  modport master (output i_BCD, output i_DV, output i_DP);
  modport slave  (input  i_BCD, input  i_DV, input  i_DP);
endinterface

// File: rtl/bcd_to_seg7.sv
// ---------------------------------------------------------------------------
// bcd_to_seg7
// Combinational nibble to active-high 7-segment glyph decoder.
//   i_Nibble : BCD digit (10..15 are shown as a dash)
//   o_Glyph  : {g,f,e,d,c,b,a}, 1 = segment lit
// ---------------------------------------------------------------------------
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_Nibble,
  output logic [6:0] o_Glyph
);

  // Glyph lookup; any non-decimal nibble falls through to the dash.
  always_comb begin
    o_Glyph = SEG_DASH;
    case (i_Nibble)
      4'd0:    o_Glyph = SEG_0;
      4'd1:    o_Glyph = SEG_1;
      4'd2:    o_Glyph = SEG_2;
      4'd3:    o_Glyph = SEG_3;
      4'd4:    o_Glyph = SEG_4;
      4'd5:    o_Glyph = SEG_5;
      4'd6:    o_Glyph = SEG_6;
      4'd7:    o_Glyph = SEG_7;
      4'd8:    o_Glyph = SEG_8;
      4'd9:    o_Glyph = SEG_9;
      default: o_Glyph = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_7seg_scan_driver.sv
// ---------------------------------------------------------------------------
// bcd_7seg_scan_driver
// Holds a packed BCD value and time-multiplexes it onto a common-anode
// multi-digit 7-segment display. Each digit slot lasts TICKS cycles, the
// first BLANK_CYCLES of which have all anodes off to suppress ghosting.
// A new value is only moved to the display at the frame boundary.
//
// Ports:
//   i_Clock    : sole clock
//   i_Reset    : synchronous active-high reset
//   i_Bus      : slave side of bcd_7seg_scan_driver_if (i_BCD, i_DV, i_DP)
//   o_Segments : {g,f,e,d,c,b,a}, active-low
//   o_DP       : decimal point, active-low
//   o_Anode    : digit enables, active-low, one-hot-low while driving
//   o_Frame    : one-cycle pulse at each frame start
//
// Optional build macro SEVSEG_LZ_BLANK_EN: leading-zero digits (k>0) are
// kept dark, DP included. Slot timing is the same in both builds.
// ---------------------------------------------------------------------------
module bcd_7seg_scan_driver
  import seg7_pkg::*;
#(
  parameter int DECIMAL_DIGITS = 4,
  parameter int CLOCK_HZ       = 100000000,
  parameter int DIGIT_HZ       = 1000,
  parameter int BLANK_CYCLES   = 16
) (
  input  logic                      i_Clock,
  input  logic                      i_Reset,
  bcd_7seg_scan_driver_if.slave     i_Bus,
  output logic [6:0]                o_Segments,
  output logic                      o_DP,
  output logic [DECIMAL_DIGITS-1:0] o_Anode,
  output logic                      o_Frame
);

  localparam int TICKS = CLOCK_HZ / DIGIT_HZ;
  localparam int TW    = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam int IW    = (DECIMAL_DIGITS > 1) ? $clog2(DECIMAL_DIGITS) : 1;

  localparam logic [TW-1:0] TICK_LAST  = TW'(TICKS - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] INDEX_LAST = IW'(DECIMAL_DIGITS - 1);

  generate
    if ((BLANK_CYCLES < 1) || (BLANK_CYCLES >= TICKS)) begin : g_bad_blank_cycles
      $fatal(1, "bcd_7seg_scan_driver: BLANK_CYCLES must satisfy 1 <= BLANK_CYCLES < TICKS");
    end
  endgenerate

  scan_state_t                 r_State;
  scan_state_t                 w_NextState;
  logic [TW-1:0]               r_Tick;
  logic [IW-1:0]               r_Index;
  logic [DECIMAL_DIGITS*4-1:0] r_Shadow;
  logic [DECIMAL_DIGITS-1:0]   r_ShadowDp;
  logic [DECIMAL_DIGITS*4-1:0] r_Display;
  logic [DECIMAL_DIGITS-1:0]   r_DisplayDp;

  logic                        w_SlotEnd;
  logic                        w_FrameWrap;
  logic [DECIMAL_DIGITS*4-1:0] w_NewDisplay;
  logic [DECIMAL_DIGITS-1:0]   w_NewDisplayDp;
  logic [3:0]                  w_Nibble;
  logic                        w_DigitDp;
  logic                        w_DigitBlank;
  logic [6:0]                  w_Glyph;
  logic [6:0]                  w_SegNext;
  logic                        w_DpNext;
  logic [DECIMAL_DIGITS-1:0]   w_AnodeNext;

  assign w_SlotEnd   = (r_Tick == TICK_LAST);
  assign w_FrameWrap = w_SlotEnd && (r_Index == INDEX_LAST);

  // A strobe landing on the transfer cycle bypasses the shadow so it is shown this frame.
  assign w_NewDisplay   = i_Bus.i_DV ? i_Bus.i_BCD : r_Shadow;
  assign w_NewDisplayDp = i_Bus.i_DV ? i_Bus.i_DP  : r_ShadowDp;

`ifdef SEVSEG_LZ_BLANK_EN
  logic [DECIMAL_DIGITS-1:0] r_BlankMask;

  // Bit k set when digit k (k>0) and every digit above it are zero.
  function automatic logic [DECIMAL_DIGITS-1:0] lz_mask(input logic [DECIMAL_DIGITS*4-1:0] v);
    logic upper_zero;
    lz_mask    = '0;
    upper_zero = 1'b1;
    for (int k = DECIMAL_DIGITS - 1; k > 0; k--) begin
      upper_zero = upper_zero & (v[4*k +: 4] == 4'h0);
      lz_mask[k] = upper_zero;
    end
  endfunction

  // Blank mask follows the display value, refreshed only at frame transfer.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_BlankMask <= lz_mask('0);
    end else if (w_FrameWrap) begin
      r_BlankMask <= lz_mask(w_NewDisplay);
    end
  end
`endif

  // Select the digit addressed by the scan index.
  always_comb begin
    w_Nibble     = 4'h0;
    w_DigitDp    = 1'b0;
    w_DigitBlank = 1'b0;
    for (int k = 0; k < DECIMAL_DIGITS; k++) begin
      w_Nibble  = w_Nibble  | ((r_Index == IW'(k)) ? r_Display[4*k +: 4] : 4'h0);
      w_DigitDp = w_DigitDp | ((r_Index == IW'(k)) ? r_DisplayDp[k]      : 1'b0);
`ifdef SEVSEG_LZ_BLANK_EN
      w_DigitBlank = w_DigitBlank | ((r_Index == IW'(k)) ? r_BlankMask[k] : 1'b0);
`endif
    end
  end

  bcd_to_seg7 u_bcd_to_seg7 (
    .i_Nibble (w_Nibble),
    .o_Glyph  (w_Glyph)
  );

  // Scan FSM next state: blank lead-in, then drive until the slot ends.
  always_comb begin
    w_NextState = s_BLANK;
    case (r_State)
      s_BLANK: begin
        if (r_Tick == BLANK_LAST) begin
          w_NextState = s_DRIVE;
        end else begin
          w_NextState = s_BLANK;
        end
      end
      s_DRIVE: begin
        if (w_SlotEnd) begin
          w_NextState = s_BLANK;
        end else begin
          w_NextState = s_DRIVE;
        end
      end
      default: w_NextState = s_BLANK;
    endcase
  end

  // Output values for the next cycle, derived from the current state.
  always_comb begin
    w_AnodeNext = '1;
    w_SegNext   = SEG_OFF;
    w_DpNext    = 1'b1;
    if ((r_State == s_DRIVE) && !w_DigitBlank) begin
      for (int k = 0; k < DECIMAL_DIGITS; k++) begin
        w_AnodeNext[k] = (r_Index == IW'(k)) ? 1'b0 : 1'b1;
      end
      w_SegNext = ~w_Glyph;
      w_DpNext  = ~w_DigitDp;
    end else begin
      w_AnodeNext = '1;
      w_SegNext   = SEG_OFF;
      w_DpNext    = 1'b1;
    end
  end

  // State, slot tick counter and digit index.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_State <= s_BLANK;
      r_Tick  <= '0;
      r_Index <= '0;
    end else begin
      r_State <= w_NextState;
      if (w_SlotEnd) begin
        r_Tick  <= '0;
        r_Index <= (r_Index == INDEX_LAST) ? '0 : (r_Index + IW'(1));
      end else begin
        r_Tick  <= r_Tick + TW'(1);
      end
    end
  end

  // Shadow capture on every strobe; display copy only at the frame wrap.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_Shadow    <= '0;
      r_ShadowDp  <= '0;
      r_Display   <= '0;
      r_DisplayDp <= '0;
    end else begin
      if (i_Bus.i_DV) begin
        r_Shadow   <= i_Bus.i_BCD;
        r_ShadowDp <= i_Bus.i_DP;
      end
      if (w_FrameWrap) begin
        r_Display   <= w_NewDisplay;
        r_DisplayDp <= w_NewDisplayDp;
      end
    end
  end

  // Registered display outputs.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      o_Anode    <= '1;
      o_Segments <= SEG_OFF;
      o_DP       <= 1'b1;
      o_Frame    <= 1'b0;
    end else begin
      o_Anode    <= w_AnodeNext;
      o_Segments <= w_SegNext;
      o_DP       <= w_DpNext;
      o_Frame    <= w_FrameWrap;
    end
  end

endmodule

// File: tb/tb_bcd_7seg_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_bcd_7seg_scan_driver
// Self-checking bench: a cycle-position model predicts every output each
// cycle, plus directed checks with hand-computed literal values.
// Configuration: TICKS=10, BLANK_CYCLES=2, 4 digits -> 40-cycle frame.
// ---------------------------------------------------------------------------
module tb_bcd_7seg_scan_driver;

  localparam int D      = 4;
  localparam int TICKS  = 10;
  localparam int BLANK  = 2;
  localparam int FRAME  = D * TICKS;

  logic       clk;
  logic       i_Reset;
  logic [6:0] o_Segments;
  logic       o_DP;
  logic [3:0] o_Anode;
  logic       o_Frame;

  int n_checks = 0;
  int n_errors = 0;

  bcd_7seg_scan_driver_if #(.DECIMAL_DIGITS(D)) bus ();

  bcd_7seg_scan_driver #(
    .DECIMAL_DIGITS (D),
    .CLOCK_HZ       (1000),
    .DIGIT_HZ       (100),
    .BLANK_CYCLES   (BLANK)
  ) dut (
    .i_Clock    (clk),
    .i_Reset    (i_Reset),
    .i_Bus      (bus),
    .o_Segments (o_Segments),
    .o_DP       (o_DP),
    .o_Anode    (o_Anode),
    .o_Frame    (o_Frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  function automatic logic [6:0] glyph_hi(input logic [3:0] n);
    case (n)
      4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
      4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
      4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
      4'd9: return 7'h6F;  default: return 7'h40;
    endcase
  endfunction

  function automatic bit digit_dark(input logic [15:0] v, input int d);
`ifdef SEVSEG_LZ_BLANK_EN
    return (d > 0) && ((v >> (4 * d)) == 16'h0);
`else
    return 1'b0;
`endif
  endfunction

  // k = number of active clock edges since reset released (k >= 1).
  function automatic int digit_of(input int k);
    return ((k - 1) / TICKS) % D;
  endfunction

  function automatic bit lit_at(input int k, input logic [15:0] v);
    return (((k - 1) % TICKS) >= BLANK) && !digit_dark(v, digit_of(k));
  endfunction

  function automatic logic [3:0] exp_anode(input int k, input logic [15:0] v);
    logic [3:0] one;
    one = 4'b0001;
    return lit_at(k, v) ? ~(one << digit_of(k)) : 4'hF;
  endfunction

  function automatic logic [6:0] exp_seg(input int k, input logic [15:0] v);
    logic [15:0] sh;
    sh = v >> (4 * digit_of(k));
    return lit_at(k, v) ? ~glyph_hi(sh[3:0]) : 7'h7F;
  endfunction

  function automatic logic exp_dp(input int k, input logic [15:0] v, input logic [3:0] dp);
    return lit_at(k, v) ? ~dp[digit_of(k)] : 1'b1;
  endfunction

  int          m_k;
  logic [15:0] m_sh, m_disp;
  logic [3:0]  m_shdp, m_dispdp;
  logic        m_valid = 1'b0;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp, e_frame;

  // Model update on each active edge.
  always @(posedge clk) begin
    if (i_Reset) begin
      m_k <= 0; m_sh <= 16'h0; m_disp <= 16'h0; m_shdp <= 4'h0; m_dispdp <= 4'h0;
      e_an <= 4'hF; e_seg <= 7'h7F; e_dp <= 1'b1; e_frame <= 1'b0; m_valid <= 1'b1;
    end else begin
      m_k     <= m_k + 1;
      e_an    <= exp_anode(m_k + 1, m_disp);
      e_seg   <= exp_seg(m_k + 1, m_disp);
      e_dp    <= exp_dp(m_k + 1, m_disp, m_dispdp);
      e_frame <= ((m_k + 1) % FRAME) == 0;
      if (bus.i_DV) begin
        m_sh <= bus.i_BCD; m_shdp <= bus.i_DP;
      end
      if (((m_k + 1) % FRAME) == 0) begin
        m_disp   <= bus.i_DV ? bus.i_BCD : m_sh;
        m_dispdp <= bus.i_DV ? bus.i_DP  : m_shdp;
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (m_valid) begin
        check("model_anode", o_Anode, e_an);
        check("model_seg",   o_Segments, e_seg);
        check("model_dp",    o_DP, e_dp);
        check("model_frame", o_Frame, e_frame);
      end
    end
  endtask

  task automatic skip(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] dp);
    bus.i_BCD = v; bus.i_DP = dp; bus.i_DV = 1'b1;
    @(negedge clk);
    bus.i_DV = 1'b0;
  endtask

  task automatic wait_frame();
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (o_Frame === 1'b1) return;
    end
    check("frame_timeout", 32'd0, 32'd1);
  endtask

  task automatic pin(input string name, input logic [3:0] an, input logic [6:0] seg, input logic dp);
    check({name, "_anode"}, o_Anode, an);
    check({name, "_seg"},   o_Segments, seg);
    check({name, "_dp"},    o_DP, dp);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int cnt;
    i_Reset = 1'b1; bus.i_BCD = 16'h0; bus.i_DV = 1'b0; bus.i_DP = 4'h0;
    fork
      compare_loop();
    join_none

    skip(3);
    pin("reset", 4'hF, 7'h7F, 1'b1);
    i_Reset = 1'b0;

    // First frame pulse after release.
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cnt++;
      if (o_Frame === 1'b1) break;
    end
    check("first_frame_latency", cnt, 40);

    // 1234: slot shape of digit 0, then digit 3.
    load(16'h1234, 4'h0);
    wait_frame();
    for (int i = 1; i <= TICKS; i++) begin
      @(negedge clk);
      if (i <= BLANK) check("d0_blank_anode", o_Anode, 4'hF);
      else            pin("d0_1234", 4'hE, 7'h19, 1'b1);
    end
    skip(25);
    pin("d3_1234", 4'h7, 7'h79, 1'b1);

    // 00A7 with DP on digit 1.
    load(16'h00A7, 4'b0010);
    wait_frame();
    skip(5);
    pin("d0_00A7", 4'hE, 7'h78, 1'b1);
    skip(10);
    pin("d1_00A7", 4'hD, 7'h3F, 1'b0);

    // 0050: leading zeros.
    load(16'h0050, 4'h0);
    wait_frame();
    skip(5);
    pin("d0_0050", 4'hE, 7'h40, 1'b1);
    skip(10);
    pin("d1_0050", 4'hD, 7'h12, 1'b1);
    skip(10);
`ifdef SEVSEG_LZ_BLANK_EN
    pin("d2_0050", 4'hF, 7'h7F, 1'b1);
    skip(10);
    pin("d3_0050", 4'hF, 7'h7F, 1'b1);
`else
    pin("d2_0050", 4'hB, 7'h40, 1'b1);
    skip(10);
    pin("d3_0050", 4'h7, 7'h40, 1'b1);
`endif

    // 0000: only digit 0 lit when leading zeros are blanked.
    load(16'h0000, 4'h0);
    wait_frame();
    skip(5);
    pin("d0_0000", 4'hE, 7'h40, 1'b1);
    skip(10);
`ifdef SEVSEG_LZ_BLANK_EN
    pin("d1_0000", 4'hF, 7'h7F, 1'b1);
`else
    pin("d1_0000", 4'hD, 7'h40, 1'b1);
`endif

    // 5555 mid-frame: current frame keeps old value, next frame shows 5.
    load(16'h5555, 4'h0);
    skip(9);
`ifdef SEVSEG_LZ_BLANK_EN
    pin("d2_hold", 4'hF, 7'h7F, 1'b1);
`else
    pin("d2_hold", 4'hB, 7'h40, 1'b1);
`endif
    wait_frame();
    skip(5);
    pin("d0_5555", 4'hE, 7'h12, 1'b1);

    // 9876 strobed on the transfer cycle: shown in that same frame.
    skip(34);
    bus.i_BCD = 16'h9876; bus.i_DP = 4'h0; bus.i_DV = 1'b1;
    @(negedge clk);
    bus.i_DV = 1'b0;
    check("coincident_frame", o_Frame, 1'b1);
    skip(5);
    pin("d0_9876", 4'hE, 7'h02, 1'b1);
    skip(10);
    pin("d1_9876", 4'hD, 7'h78, 1'b1);

    // Reset mid s_DRIVE of digit 2.
    skip(10);
    check("pre_reset_d2_anode", o_Anode, 4'hB);
    i_Reset = 1'b1;
    @(negedge clk);
    pin("mid_reset", 4'hF, 7'h7F, 1'b1);
    check("mid_reset_frame", o_Frame, 1'b0);
    i_Reset = 1'b0;
    skip(5);
    pin("post_reset_d0", 4'hE, 7'h40, 1'b1);
    skip(10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
